// File: rtl/read_bus_arbiter.sv
// read_bus_arbiter
//
// Two-to-one round-robin arbiter that shares one memory read port between the
// instruction-fetch channel (i_*) and the load channel (d_*). Exactly one
// transaction is outstanding at a time; each response is routed back to the
// requester that issued it.
//
// Ports:
//   clock, reset          system clock (rising edge), asynchronous active-low reset
//   i_raddr_valid/ready   fetch address handshake, i_raddr fetch address
//   i_rdata_valid/ready   fetch data handshake, i_rdata fetch data
//   d_raddr_valid/ready   load address handshake, d_raddr load address
//   d_rdata_valid/ready   load data handshake, d_rdata load data
//   m_raddr_valid/ready   shared address handshake (valid registered), m_raddr registered address
//   m_rdata_valid/ready   shared data handshake, m_rdata memory data
//   grant_d               current or last grant: 0 = fetch, 1 = load (registered)

module read_bus_arbiter #(
    parameter int unsigned addr_width = 32,
    parameter int unsigned data_width = 32
) (
    input  logic                  clock,
    input  logic                  reset,

    input  logic                  i_raddr_valid,
    output logic                  i_raddr_ready,
    input  logic [addr_width-1:0] i_raddr,
    output logic                  i_rdata_valid,
    input  logic                  i_rdata_ready,
    output logic [data_width-1:0] i_rdata,

    input  logic                  d_raddr_valid,
    output logic                  d_raddr_ready,
    input  logic [addr_width-1:0] d_raddr,
    output logic                  d_rdata_valid,
    input  logic                  d_rdata_ready,
    output logic [data_width-1:0] d_rdata,

    output logic                  m_raddr_valid,
    input  logic                  m_raddr_ready,
    output logic [addr_width-1:0] m_raddr,
    input  logic                  m_rdata_valid,
    output logic                  m_rdata_ready,
    input  logic [data_width-1:0] m_rdata,

    output logic                  grant_d
);

    typedef enum logic [1:0] {
        StIdle,
        StAddr,
        StData
    } state_e;

    state_e                  state_q, state_d;
    logic [addr_width-1:0]   m_raddr_q, m_raddr_d;
    logic                    m_raddr_valid_q, m_raddr_valid_d;
    logic                    last_grant_q, last_grant_d;

    logic                    any_req;
    logic                    pick;
    logic                    granted_rdata_ready;

    // Arbitration: a lone requester always wins; on contention the channel
    // that was not granted last wins.
    always_comb begin
        any_req = i_raddr_valid | d_raddr_valid;
        if (i_raddr_valid && d_raddr_valid) begin
            pick = ~last_grant_q;
        end else begin
            pick = d_raddr_valid;
        end
    end

    assign granted_rdata_ready = last_grant_q ? d_rdata_ready : i_rdata_ready;

    // Next-state and output logic.
    always_comb begin
        state_d         = state_q;
        m_raddr_d       = m_raddr_q;
        m_raddr_valid_d = m_raddr_valid_q;
        last_grant_d    = last_grant_q;

        i_raddr_ready   = 1'b0;
        d_raddr_ready   = 1'b0;
        i_rdata_valid   = 1'b0;
        d_rdata_valid   = 1'b0;
        m_rdata_ready   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (any_req) begin
                    // The address readies are combinational from the request
                    // valids, so they are masked by reset explicitly to keep
                    // every handshake output low while reset is held.
                    i_raddr_ready   = reset & ~pick;
                    d_raddr_ready   = reset & pick;
                    m_raddr_d       = pick ? d_raddr : i_raddr;
                    m_raddr_valid_d = 1'b1;
                    last_grant_d    = pick;
                    state_d         = StAddr;
                end
            end

            StAddr: begin
                if (m_raddr_ready) begin
                    m_raddr_valid_d = 1'b0;
                    state_d         = StData;
                end
            end

            StData: begin
                // Passthrough only to the granted channel; the other one sees
                // no valid and its ready is ignored.
                m_rdata_ready = granted_rdata_ready;
                if (last_grant_q) begin
                    d_rdata_valid = m_rdata_valid;
                end else begin
                    i_rdata_valid = m_rdata_valid;
                end
                if (m_rdata_valid && granted_rdata_ready) begin
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q         <= StIdle;
            m_raddr_q       <= '0;
            m_raddr_valid_q <= 1'b0;
            // Load counts as granted last, so fetch wins the first contention.
            last_grant_q    <= 1'b1;
        end else begin
            state_q         <= state_d;
            m_raddr_q       <= m_raddr_d;
            m_raddr_valid_q <= m_raddr_valid_d;
            last_grant_q    <= last_grant_d;
        end
    end

    assign m_raddr       = m_raddr_q;
    assign m_raddr_valid = m_raddr_valid_q;
    assign grant_d       = last_grant_q;

    // Read data is broadcast; only the channel with rdata_valid high uses it.
    assign i_rdata = m_rdata;
    assign d_rdata = m_rdata;

endmodule

// File: tb/tb_read_bus_arbiter.sv
// Directed self-checking bench for read_bus_arbiter. The bench plays both
// requesters and the memory; expected responses go into a scoreboard queue
// when a request is issued and are popped at the data handshake.

module tb_read_bus_arbiter;

    logic        clock;
    logic        reset;
    logic        i_raddr_valid, i_raddr_ready, i_rdata_valid, i_rdata_ready;
    logic [31:0] i_raddr, i_rdata;
    logic        d_raddr_valid, d_raddr_ready, d_rdata_valid, d_rdata_ready;
    logic [31:0] d_raddr, d_rdata;
    logic        m_raddr_valid, m_raddr_ready, m_rdata_valid, m_rdata_ready;
    logic [31:0] m_raddr, m_rdata;
    logic        grant_d;

    typedef struct {
        logic        ch;
        logic [31:0] data;
    } sb_t;

    sb_t sb[$];
    int  checks = 0;
    int  errors = 0;

    read_bus_arbiter #(
        .addr_width(32),
        .data_width(32)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .i_raddr_valid(i_raddr_valid),
        .i_raddr_ready(i_raddr_ready),
        .i_raddr      (i_raddr),
        .i_rdata_valid(i_rdata_valid),
        .i_rdata_ready(i_rdata_ready),
        .i_rdata      (i_rdata),
        .d_raddr_valid(d_raddr_valid),
        .d_raddr_ready(d_raddr_ready),
        .d_raddr      (d_raddr),
        .d_rdata_valid(d_rdata_valid),
        .d_rdata_ready(d_rdata_ready),
        .d_rdata      (d_rdata),
        .m_raddr_valid(m_raddr_valid),
        .m_raddr_ready(m_raddr_ready),
        .m_raddr      (m_raddr),
        .m_rdata_valid(m_rdata_valid),
        .m_rdata_ready(m_rdata_ready),
        .m_rdata      (m_rdata),
        .grant_d      (grant_d)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory contents as seen by the bench.
    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        if (a == 32'h0000_0100) return 32'hDEAD_BEEF;
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One complete transaction starting from IDLE with the request valids
    // already driven. exp_g is the channel the bench expects to win.
    task automatic run_txn(input logic exp_g, input logic drop, input int addr_stall,
                           input int data_stall, input logic early);
        logic [31:0] ea;
        logic [31:0] ed;
        logic        gready;
        sb_t         e;
        ea = exp_g ? d_raddr : i_raddr;
        ed = mem_fn(ea);

        @(negedge clock);
        chk("win_raddr_ready", exp_g ? d_raddr_ready : i_raddr_ready, 1);
        chk("lose_raddr_ready", exp_g ? i_raddr_ready : d_raddr_ready, 0);
        chk("m_raddr_valid_idle", m_raddr_valid, 0);
        sb.push_back('{ch: exp_g, data: ed});

        @(posedge clock); #1;
        if (drop) begin
            if (exp_g) d_raddr_valid = 1'b0;
            else       i_raddr_valid = 1'b0;
        end
        m_raddr_ready = (addr_stall == 0);
        if (early && addr_stall > 0) begin
            m_rdata_valid = 1'b1;
            m_rdata       = 32'hBAD0_0BAD;
        end
        for (int k = 0; k <= addr_stall; k++) begin
            @(negedge clock);
            chk("m_raddr_valid", m_raddr_valid, 1);
            chk("m_raddr", m_raddr, ea);
            chk("grant_d", grant_d, exp_g);
            chk("i_raddr_ready_addr", i_raddr_ready, 0);
            chk("d_raddr_ready_addr", d_raddr_ready, 0);
            chk("m_rdata_ready_addr", m_rdata_ready, 0);
            chk("i_rdata_valid_addr", i_rdata_valid, 0);
            chk("d_rdata_valid_addr", d_rdata_valid, 0);
            @(posedge clock); #1;
            if (k + 1 == addr_stall) begin
                m_raddr_ready = 1'b1;
                m_rdata_valid = 1'b0;
            end
        end
        m_raddr_ready = 1'b0;

        m_rdata_valid = 1'b1;
        m_rdata       = ed;
        gready        = (data_stall == 0);
        // Ungranted ready held high: it must not leak into m_rdata_ready.
        if (exp_g) begin d_rdata_ready = gready; i_rdata_ready = 1'b1; end
        else       begin i_rdata_ready = gready; d_rdata_ready = 1'b1; end
        for (int k = 0; k <= data_stall; k++) begin
            @(negedge clock);
            chk("m_raddr_valid_data", m_raddr_valid, 0);
            chk("granted_rdata_valid", exp_g ? d_rdata_valid : i_rdata_valid, 1);
            chk("ungranted_rdata_valid", exp_g ? i_rdata_valid : d_rdata_valid, 0);
            chk("m_rdata_ready", m_rdata_ready, (k == data_stall));
            chk("i_raddr_ready_data", i_raddr_ready, 0);
            chk("d_raddr_ready_data", d_raddr_ready, 0);
            chk("m_raddr_stable", m_raddr, ea);
            if (k == data_stall) begin
                if (sb.size() == 0) begin
                    chk("sb_nonempty", 0, 1);
                end else begin
                    e = sb.pop_front();
                    chk("resp_channel", d_rdata_valid, e.ch);
                    chk("resp_data", d_rdata_valid ? d_rdata : i_rdata, e.data);
                end
            end
            @(posedge clock); #1;
            if (k + 1 == data_stall) begin
                if (exp_g) d_rdata_ready = 1'b1;
                else       i_rdata_ready = 1'b1;
            end
        end
        m_rdata_valid = 1'b0;
        i_rdata_ready = 1'b0;
        d_rdata_ready = 1'b0;
    endtask

    initial begin
        reset         = 1'b0;
        i_raddr_valid = 1'b1;
        d_raddr_valid = 1'b1;
        i_raddr       = 32'h0000_0100;
        d_raddr       = 32'h0000_2000;
        i_rdata_ready = 1'b0;
        d_rdata_ready = 1'b0;
        m_raddr_ready = 1'b0;
        m_rdata_valid = 1'b0;
        m_rdata       = '0;

        // Reset held with both requests pending.
        repeat (5) begin
            @(negedge clock);
            chk("rst_i_raddr_ready", i_raddr_ready, 0);
            chk("rst_d_raddr_ready", d_raddr_ready, 0);
            chk("rst_m_raddr_valid", m_raddr_valid, 0);
            chk("rst_m_raddr", m_raddr, 0);
            chk("rst_grant_d", grant_d, 1);
            chk("rst_rdata_valids", {i_rdata_valid, d_rdata_valid, m_rdata_ready}, 0);
        end
        @(posedge clock); #1;
        reset = 1'b1;

        // Contention: both valids stay high, grants alternate I,D,I,D,I,D.
        run_txn(0, 0, 0, 0, 0);
        run_txn(1, 0, 0, 0, 0);
        run_txn(0, 0, 0, 0, 0);
        run_txn(1, 0, 0, 0, 0);
        run_txn(0, 0, 0, 0, 0);
        run_txn(1, 1, 0, 0, 0);
        run_txn(0, 1, 0, 0, 0);

        // Fetch only, twice: a lone requester wins even if granted last.
        i_raddr_valid = 1'b1;
        i_raddr       = 32'h0000_0100;
        run_txn(0, 1, 0, 0, 0);
        i_raddr_valid = 1'b1;
        run_txn(0, 1, 0, 0, 0);

        // Backpressure with a competing fetch pending the whole time.
        i_raddr       = 32'h0000_0300;
        i_raddr_valid = 1'b1;
        d_raddr_valid = 1'b1;
        run_txn(1, 1, 4, 3, 0);
        run_txn(0, 1, 0, 0, 0);

        // Early data pulse while in ADDR.
        d_raddr       = 32'h0000_2040;
        d_raddr_valid = 1'b1;
        run_txn(1, 1, 2, 0, 1);

        // Reset in the middle of the data phase.
        i_raddr       = 32'h0000_0400;
        i_raddr_valid = 1'b1;
        @(negedge clock);
        chk("mid_i_raddr_ready", i_raddr_ready, 1);
        sb.push_back('{ch: 1'b0, data: mem_fn(32'h0000_0400)});
        @(posedge clock); #1;
        i_raddr_valid = 1'b0;
        m_raddr_ready = 1'b1;
        @(posedge clock); #1;
        m_raddr_ready = 1'b0;
        m_rdata_valid = 1'b1;
        m_rdata       = mem_fn(32'h0000_0400);
        i_rdata_ready = 1'b1;
        @(negedge clock);
        chk("mid_i_rdata_valid", i_rdata_valid, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_i_rdata_valid", i_rdata_valid, 0);
        chk("mid_rst_m_rdata_ready", m_rdata_ready, 0);
        chk("mid_rst_m_raddr_valid", m_raddr_valid, 0);
        chk("mid_rst_grant_d", grant_d, 1);
        sb.delete();
        @(posedge clock); #1;
        @(negedge clock);
        chk("mid_rst_hold_i_rdata_valid", i_rdata_valid, 0);
        chk("mid_rst_hold_d_rdata_valid", d_rdata_valid, 0);
        @(posedge clock); #1;
        m_rdata_valid = 1'b0;
        i_rdata_ready = 1'b0;
        reset         = 1'b1;

        // Clean restart: pointer back at its reset value, fetch wins first.
        i_raddr       = 32'h0000_0500;
        d_raddr       = 32'h0000_2100;
        i_raddr_valid = 1'b1;
        d_raddr_valid = 1'b1;
        run_txn(0, 1, 0, 0, 0);
        run_txn(1, 1, 0, 0, 0);

        @(negedge clock);
        chk("sb_empty", sb.size(), 0);
        chk("idle_m_raddr_valid", m_raddr_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
